// File: rtl/sprite_pkg.sv
// Shared definitions for the sprite pipeline: attribute word layout, screen
// constants, scheduler state encoding and the per-line row hit test.
package sprite_pkg;

  localparam int EN_BIT    = 31;
  localparam int FLIP_BIT  = 30;
  localparam int X_MSB     = 29;
  localparam int X_LSB     = 20;
  localparam int Y_MSB     = 19;
  localparam int Y_LSB     = 10;
  localparam int FRAME_MSB = 7;
  localparam int FRAME_LSB = 0;

  localparam int SPRITE_W  = 16;
  localparam int SPRITE_H  = 16;
  localparam int SCREEN_W  = 640;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    EVAL,
    ISSUE,
    BUSY,
    DRAIN
  } state_t;

  typedef struct packed {
    logic       hit;
    logic [3:0] row_off;
  } row_hit_t;

  // A borrow out of the 11-bit difference means the sprite starts below the line.
  function automatic row_hit_t sprite_row_hit(input logic [9:0] line_y, input logic [9:0] y);
    logic [10:0] diff;
    row_hit_t    r;
    diff      = {1'b0, line_y} - {1'b0, y};
    r.hit     = ~diff[10] & (diff[9:4] == 6'd0);
    r.row_off = diff[3:0];
    return r;
  endfunction

endpackage

// File: rtl/sprite_line_scheduler.sv
// Per-scanline sequencer: scans the sprite attribute RAM in index order and
// hands each sprite that covers the target line to the row drawer, one at a time.
module sprite_line_scheduler
  import sprite_pkg::*;
#(
  parameter int NUM_SPRITES  = 32,
  parameter int MAX_PER_LINE = 16,
  parameter int AW           = $clog2(NUM_SPRITES)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          line_start,
  input  logic [9:0]    line_y,
  output logic [AW-1:0] attr_addr,
  input  logic [31:0]   attr_q,
  output logic          drw_start,
  output logic [9:0]    drw_col_base,
  output logic          drw_flip,
  output logic [7:0]    drw_frame_id,
  output logic [3:0]    drw_row_off,
  input  logic          drw_done,
  output logic          busy,
  output logic          line_done,
  output logic          overflow,
  output logic          late
);

  localparam int            CW       = $clog2(MAX_PER_LINE + 1);
  localparam logic [AW-1:0] LAST_IDX = AW'(NUM_SPRITES - 1);

  state_t        state, state_n;
  logic [AW-1:0] idx, idx_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [9:0]    target_y, target_y_n;
  logic [AW-1:0] attr_addr_n;
  logic          drw_start_n;
  logic [9:0]    drw_col_base_n;
  logic          drw_flip_n;
  logic [7:0]    drw_frame_id_n;
  logic [3:0]    drw_row_off_n;
  logic          busy_n;
  logic          line_done_n;
  logic          overflow_n;
  logic          late_n;
  logic          finish;
  row_hit_t      rh;

  logic unused_attr;
  assign unused_attr = ^attr_q[9:8];

  always_comb begin
    state_n        = state;
    idx_n          = idx;
    cnt_n          = cnt;
    target_y_n     = target_y;
    drw_start_n    = 1'b0;
    drw_col_base_n = drw_col_base;
    drw_flip_n     = drw_flip;
    drw_frame_id_n = drw_frame_id;
    drw_row_off_n  = drw_row_off;
    line_done_n    = 1'b0;
    overflow_n     = overflow;
    late_n         = 1'b0;
    finish         = 1'b0;
    rh             = sprite_row_hit(target_y, attr_q[Y_MSB:Y_LSB]);

    case (state)
      IDLE: begin
        if (line_start) begin
          target_y_n = line_y;
          idx_n      = '0;
          cnt_n      = '0;
          overflow_n = 1'b0;
          state_n    = FETCH;
        end
      end
      FETCH: state_n = EVAL;
      EVAL: begin
        if (attr_q[EN_BIT] && rh.hit) begin
          if (cnt < CW'(MAX_PER_LINE)) begin
            drw_col_base_n = attr_q[X_MSB:X_LSB];
            drw_flip_n     = attr_q[FLIP_BIT];
            drw_frame_id_n = attr_q[FRAME_MSB:FRAME_LSB];
            drw_row_off_n  = rh.row_off;
            drw_start_n    = 1'b1;
            state_n        = ISSUE;
          end else begin
            overflow_n = 1'b1;
            finish     = 1'b1;
          end
        end else if (idx == LAST_IDX) begin
          finish = 1'b1;
        end else begin
          idx_n   = idx + AW'(1);
          state_n = FETCH;
        end
      end
      ISSUE: state_n = BUSY;
      BUSY: begin
        if (drw_done) begin
          cnt_n = cnt + CW'(1);
          if (idx == LAST_IDX) begin
            finish = 1'b1;
          end else begin
            idx_n   = idx + AW'(1);
            state_n = FETCH;
          end
        end
      end
      DRAIN: begin
        if (drw_done) begin
          idx_n   = '0;
          cnt_n   = '0;
          state_n = FETCH;
        end
      end
      default: state_n = IDLE;
    endcase

    if (finish) begin
      state_n     = IDLE;
      line_done_n = 1'b1;
    end

    // A new line while busy aborts the current one; an in-flight draw must finish first.
    if (line_start && state != IDLE) begin
      late_n         = 1'b1;
      target_y_n     = line_y;
      overflow_n     = 1'b0;
      line_done_n    = 1'b0;
      drw_start_n    = 1'b0;
      drw_col_base_n = drw_col_base;
      drw_flip_n     = drw_flip;
      drw_frame_id_n = drw_frame_id;
      drw_row_off_n  = drw_row_off;
      if (state == FETCH || state == EVAL) begin
        idx_n   = '0;
        cnt_n   = '0;
        state_n = FETCH;
      end else begin
        state_n = DRAIN;
      end
    end

    // The RAM registers the address at the end of FETCH, so present it on entry.
    attr_addr_n = (state_n == FETCH) ? idx_n : attr_addr;
    busy_n      = (state_n != IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      idx          <= '0;
      cnt          <= '0;
      target_y     <= '0;
      attr_addr    <= '0;
      drw_start    <= 1'b0;
      drw_col_base <= '0;
      drw_flip     <= 1'b0;
      drw_frame_id <= '0;
      drw_row_off  <= '0;
      busy         <= 1'b0;
      line_done    <= 1'b0;
      overflow     <= 1'b0;
      late         <= 1'b0;
    end else begin
      state        <= state_n;
      idx          <= idx_n;
      cnt          <= cnt_n;
      target_y     <= target_y_n;
      attr_addr    <= attr_addr_n;
      drw_start    <= drw_start_n;
      drw_col_base <= drw_col_base_n;
      drw_flip     <= drw_flip_n;
      drw_frame_id <= drw_frame_id_n;
      drw_row_off  <= drw_row_off_n;
      busy         <= busy_n;
      line_done    <= line_done_n;
      overflow     <= overflow_n;
      late         <= late_n;
    end
  end

endmodule

// File: tb/tb_sprite_line_scheduler.sv
// Bench for sprite_line_scheduler: attribute RAM and drawer models around the DUT,
// with expected draw lists computed from sprite geometry by a reference model.
module tb_sprite_line_scheduler;

  localparam int NS  = 32;
  localparam int MPL = 16;
  localparam int AW  = 5;
  localparam int SH  = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic          line_start;
  logic [9:0]    line_y;
  logic [AW-1:0] attr_addr;
  logic [31:0]   attr_q;
  logic          drw_start;
  logic [9:0]    drw_col_base;
  logic          drw_flip;
  logic [7:0]    drw_frame_id;
  logic [3:0]    drw_row_off;
  logic          drw_done;
  logic          busy;
  logic          line_done;
  logic          overflow;
  logic          late;

  logic [31:0] mem [NS];
  logic [22:0] got_q[$];
  logic [22:0] exp_q[$];

  int n_chk = 0;
  int n_pass = 0;
  int n_done = 0;
  int n_late = 0;
  int stable_err = 0;
  int overlap_err = 0;
  int lat_min = 1;
  int lat_max = 8;
  int left;
  bit hold = 1'b0;
  logic [10:0] held;

  sprite_line_scheduler dut (
    .clk(clk), .reset(reset), .line_start(line_start), .line_y(line_y),
    .attr_addr(attr_addr), .attr_q(attr_q), .drw_start(drw_start),
    .drw_col_base(drw_col_base), .drw_flip(drw_flip), .drw_frame_id(drw_frame_id),
    .drw_row_off(drw_row_off), .drw_done(drw_done), .busy(busy),
    .line_done(line_done), .overflow(overflow), .late(late)
  );

  always #5 clk = ~clk;

  always @(posedge clk) attr_q <= mem[attr_addr];

  // Drawer: drops done for a random number of cycles after each start.
  always @(posedge clk) begin
    if (reset) begin
      drw_done <= 1'b1;
      left     <= 0;
    end else if (drw_start) begin
      drw_done <= 1'b0;
      left     <= $urandom_range(lat_min, lat_max);
    end else if (left > 0) begin
      left <= left - 1;
      if (left == 1) drw_done <= 1'b1;
    end
  end

  always @(negedge clk) begin
    if (reset) begin
      hold = 1'b0;
    end else begin
      if (drw_start) begin
        if (hold) overlap_err++;
        got_q.push_back({drw_col_base, drw_flip, drw_frame_id, drw_row_off});
        held = {drw_col_base, drw_flip};
        hold = 1'b1;
      end else if (hold) begin
        if (drw_done) hold = 1'b0;
        else if ({drw_col_base, drw_flip} != held) stable_err++;
      end
      if (line_done) n_done++;
      if (late) n_late++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_chk++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, want);
  endtask

  // Reference: every enabled sprite whose 16 rows cover the line, in index order.
  task automatic model_line(input int ly, output bit ovf);
    int nhit;
    int d;
    exp_q.delete();
    nhit = 0;
    for (int i = 0; i < NS; i++) begin
      if (mem[i][31]) begin
        d = ly - int'(mem[i][19:10]);
        if (d >= 0 && d < SH) begin
          nhit++;
          if (nhit <= MPL) exp_q.push_back({mem[i][29:20], mem[i][30], mem[i][7:0], 4'(d)});
        end
      end
    end
    ovf = (nhit > MPL);
  endtask

  task automatic start_line(input int y);
    @(posedge clk);
    #1;
    line_y     = 10'(y);
    line_start = 1'b1;
    @(posedge clk);
    #1;
    line_start = 1'b0;
  endtask

  task automatic wait_done(output int cyc);
    cyc = 0;
    while (!line_done && cyc < 2000) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    if (!line_done) chk("line_done_timeout", 0, 1);
    @(negedge clk);
    #1;
  endtask

  task automatic wait_start();
    int k = 0;
    while (!drw_start && k < 200) begin
      @(posedge clk);
      #1;
      k++;
    end
    if (!drw_start) chk("start_timeout", 0, 1);
  endtask

  task automatic compare_line(input string tag, input bit ovf);
    chk({tag, "_count"}, got_q.size(), exp_q.size());
    if (got_q.size() == exp_q.size())
      for (int i = 0; i < exp_q.size(); i++) chk({tag, "_cmd"}, 32'(got_q[i]), 32'(exp_q[i]));
    chk({tag, "_overflow"}, overflow, ovf);
    chk({tag, "_stable"}, stable_err, 0);
    chk({tag, "_overlap"}, overlap_err, 0);
  endtask

  task automatic run_line(input string tag, input int y, output int cyc);
    bit ovf;
    model_line(y, ovf);
    got_q.delete();
    n_done = 0;
    start_line(y);
    chk({tag, "_busy_rise"}, busy, 1);
    wait_done(cyc);
    compare_line(tag, ovf);
    chk({tag, "_ndone"}, n_done, 1);
    chk({tag, "_busy_fall"}, busy, 0);
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_addr"}, 32'(attr_addr), 0);
    chk({tag, "_drw"}, {drw_start, drw_col_base, drw_flip, drw_frame_id, drw_row_off}, 0);
    chk({tag, "_status"}, {busy, line_done, overflow, late}, 0);
  endtask

  task automatic clear_mem();
    for (int i = 0; i < NS; i++) mem[i] = '0;
  endtask

  initial begin
    int cyc;
    int ly;
    bit ovf;
    logic [9:0] yv;
    logic [22:0] e;

    clear_mem();
    reset      = 1'b1;
    line_start = 1'b0;
    line_y     = '0;
    repeat (3) @(posedge clk);
    #1;
    check_reset("reset");
    reset = 1'b0;

    // Empty table
    run_line("empty", 100, cyc);
    chk("empty_latency", cyc, 64);
    chk("empty_starts", got_q.size(), 0);

    // Single sprite at index 3
    mem[3] = {1'b1, 1'b1, 10'd200, 10'd95, 2'b00, 8'h12};
    lat_min = 17; lat_max = 17;
    run_line("s3", 100, cyc);
    if (got_q.size() == 1) begin
      e = got_q[0];
      chk("s3_col", 32'(e[22:13]), 200);
      chk("s3_flip", 32'(e[12]), 1);
      chk("s3_frame", 32'(e[11:4]), 32'h12);
      chk("s3_row", 32'(e[3:0]), 5);
    end

    // Row window boundaries
    clear_mem();
    mem[0] = {1'b1, 1'b0, 10'd10, 10'd100, 2'b00, 8'h01};
    mem[1] = {1'b1, 1'b0, 10'd20, 10'd85, 2'b00, 8'h02};
    mem[2] = {1'b1, 1'b0, 10'd30, 10'd84, 2'b00, 8'h03};
    mem[3] = {1'b1, 1'b0, 10'd40, 10'd101, 2'b00, 8'h04};
    lat_min = 1; lat_max = 8;
    run_line("edge", 100, cyc);
    if (got_q.size() == 2) begin
      e = got_q[0];
      chk("edge_row0", 32'(e[3:0]), 0);
      e = got_q[1];
      chk("edge_row15", 32'(e[3:0]), 15);
    end

    // Overflow: 20 hits, only indices 0..15 issued
    clear_mem();
    for (int i = 0; i < 20; i++) mem[i] = {1'b1, 1'b0, 10'(i * 8), 10'd0, 2'b00, 8'(i)};
    run_line("ovf", 0, cyc);
    if (got_q.size() == 16) begin
      for (int i = 0; i < 16; i++) begin
        e = got_q[i];
        chk("ovf_index", 32'(e[11:4]), i);
      end
    end

    // Random tables and lines
    for (int t = 0; t < 8; t++) begin
      ly = $urandom_range(0, 1023);
      for (int i = 0; i < NS; i++) begin
        yv = 10'(ly + 4 - int'($urandom_range(0, 23)));
        mem[i] = {1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  10'($urandom_range(0, 1023)), yv, 2'($urandom_range(0, 3)),
                  8'($urandom_range(0, 255))};
      end
      run_line("rand", ly, cyc);
    end

    // New line arrives while the drawer is busy
    clear_mem();
    mem[2] = {1'b1, 1'b0, 10'd50, 10'd6, 2'b00, 8'h20};
    mem[5] = {1'b1, 1'b1, 10'd60, 10'd2, 2'b00, 8'h21};
    mem[9] = {1'b1, 1'b0, 10'd70, 10'd7, 2'b00, 8'h22};
    lat_min = 12; lat_max = 12;
    n_done = 0;
    start_line(6);
    wait_start();
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    got_q.delete();
    n_done = 0;
    n_late = 0;
    model_line(7, ovf);
    start_line(7);
    chk("late_pulse", late, 1);
    wait_done(cyc);
    compare_line("late", ovf);
    chk("late_ndone", n_done, 1);
    chk("late_nlate", n_late, 1);

    // Reset in the middle of a draw
    lat_min = 10; lat_max = 10;
    start_line(6);
    wait_start();
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    reset = 1'b1;
    @(posedge clk);
    #1;
    check_reset("midrst");
    reset = 1'b0;
    lat_min = 1; lat_max = 8;
    run_line("after_rst", 7, cyc);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
